// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and helpers for the FIFO write-side arbiter
// and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DW     = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned BEAT_CW    = 4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((32'd1 << r) < v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from the slot after i_rr_last, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_last,
  output logic          o_any_req,
  output logic [IW-1:0] o_idx
);

  assign o_any_req = |i_req;

  always_comb begin
    logic          found;
    int unsigned   cand;
    logic [IW-1:0] w_cand_idx;
    found      = 1'b0;
    cand       = 0;
    w_cand_idx = '0;
    o_idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand       = (32'(i_rr_last) + k) % N;
      w_cand_idx = IW'(cand);
      if (!found && i_req[w_cand_idx]) begin
        found = 1'b1;
        o_idx = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO between N_REQ producers
// with bounded bursts. Optional per-producer beat counters: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DW        = DEF_DW,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IW        = clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]  req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DW-1:0]     fifo_din,
  output logic [IW-1:0]     grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic [IW-1:0]     stat_sel,
  output logic [15:0]       stat_count,
`endif
  output logic              busy
);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IW-1:0]      r_grant_id;
  logic [IW-1:0]      r_rr_last;
  logic [BEAT_CW-1:0] r_beat_cnt;
  logic [IW-1:0]      w_pick_idx;
  logic               w_any_req;
  logic               w_in_burst;
  logic               w_sel_valid;
  logic               w_xfer;
  logic               w_last_beat;
  logic               w_burst_end;
  logic [DW-1:0]      w_req_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DW +: DW];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req     (req_valid),
    .i_rr_last (r_rr_last),
    .o_any_req (w_any_req),
    .o_idx     (w_pick_idx)
  );

  // Transfer qualification; reset suppresses any write in its own cycle.
  assign w_in_burst  = (r_state == BURST);
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_xfer      = w_in_burst & w_sel_valid & ~fifo_full & ~reset;
  assign w_last_beat = (r_beat_cnt == BEAT_CW'(MAX_BURST - 1));
  assign w_burst_end = w_in_burst & (~w_sel_valid | (w_xfer & w_last_beat));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req)   w_state_nxt = BURST;
      BURST:   if (w_burst_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    grant_id   = '0;
    if (!reset) begin
      grant_id = r_grant_id;
      if (w_in_burst) begin
        busy                  = 1'b1;
        req_ready[r_grant_id] = ~fifo_full;
        fifo_wr_en            = w_xfer;
        fifo_din              = w_req_data[r_grant_id];
      end
    end
  end

  // Grant, beat counter and round-robin pointer; rr_last starts at the top
  // slot so producer 0 wins the first arbitration after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_rr_last  <= IW'(N_REQ - 1);
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end
      if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_burst_end) begin
        r_rr_last <= r_grant_id;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat_cnt [N_REQ];
  logic [15:0] r_stat_count;

  // Saturating per-producer beat counters with a registered readout mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        r_stat_cnt[i] <= '0;
      end
      r_stat_count <= '0;
    end else begin
      if (w_xfer && (r_stat_cnt[r_grant_id] != 16'hFFFF)) begin
        r_stat_cnt[r_grant_id] <= r_stat_cnt[r_grant_id] + 16'd1;
      end
      r_stat_count <= r_stat_cnt[stat_sel];
    end
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter sharing one 16-deep x 8-bit synchronous FIFO between N producers.
- Each producer has a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst and drives the FIFO wr_en/din.
- Honours FIFO full back-pressure.
- Sits between producer blocks and the FIFO write side; the FIFO read side is untouched.

Parameters:
- N_REQ, 4, number of producers (2..8).
- DW, 8, data width; matches the FIFO.
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-producer data valid
- req_data  input  N_REQ*DW  packed producer data; producer i occupies bits [i*DW +: DW]
- req_ready  output  N_REQ  per-producer accept; transfer when valid & ready
- fifo_full  input  1  FIFO full flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_din  output  DW  FIFO write data
- grant_id  output  clog2(N_REQ)  current/last granted producer
- busy  output  1  high while in BURST

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, grant_id=0, beat_cnt=0, rr_last=N_REQ-1 so producer 0 has highest priority. All outputs are 0 during and after reset.
- Reset mid-burst aborts the burst. No write occurs in the reset cycle.
- FSM has two states, IDLE and BURST.
- IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid, pick the first set bit scanning rr_last+1, rr_last+2, ... modulo N_REQ.
  - Register it into grant_id, clear beat_cnt, go to BURST.
  - Latency: 1 cycle from valid to grant; the first transfer can occur on the 2nd edge.
- BURST with g=grant_id:
  - req_ready[g] = !fifo_full; all other ready bits are 0.
  - fifo_wr_en = req_valid[g] & !fifo_full, combinational from registered state.
  - fifo_din = req_data slice g, driven regardless of wr_en.
  - Each transfer increments beat_cnt (4-bit counter).
- Burst end, leading to IDLE with rr_last=g:
  - (a) a transfer occurs with beat_cnt==MAX_BURST-1; or
  - (b) req_valid[g]==0 in a cycle.
- Re-arbitration bubble: one IDLE cycle between bursts, so the same producer cannot monopolise the FIFO.
- fifo_full during BURST: stall; stay in BURST, beat_cnt holds, no write. Valid held by the producer is not a burst end.
- Producer data must stay stable while valid & !ready. The arbiter never drops or duplicates a beat.
- Single requester only: it is re-granted after each bubble. Throughput is MAX_BURST/(MAX_BURST+1).
- busy = (state==BURST).
- Simultaneous requests: strict round-robin order. A producer is skipped only if its valid is low at the arbitration cycle.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds input stat_sel (clog2(N_REQ)) and output stat_count (16 bits).
  - Adds one 16-bit saturating beat counter per producer, incremented on each accepted transfer and cleared by reset.
  - stat_count shows the counter selected by stat_sel, registered, with 1-cycle latency.
- Not defined: no stats ports and no counters; all other behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum (IDLE, BURST);
  - default widths DW=8 and FIFO_DEPTH=16;
  - function clog2.
- One natural sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and rr_last.
  - Outputs: any_req and idx.
  - Reusable by a later read-side scheduler.

Test Plan:
- Reset then req_valid=4'b1111, all data constant -> grants in order 0,1,2,3,0; each grant gives 4 writes then 1 idle cycle; fifo_wr_en pattern 11110 repeating.
- Only producer 2 valid with data 0xA0..0xA9 (10 beats) -> FIFO receives 0xA0..0xA9 in order; bubbles after beats 4 and 8; grant_id=2 throughout.
- Producer 1 in BURST after 2 beats, fifo_full=1 for 5 cycles -> req_ready[1]=0 and no wr_en while full; after full drops, exactly 2 more beats are written, then IDLE.
- Producer 0 drops valid after 1 beat while producer 3 is valid -> burst ends; next grant goes to producer 3; rr_last=0.
- Reset asserted in the middle of a burst (beat 2) -> next cycle state=IDLE, busy=0, grant_id=0, no write in the reset cycle; with all four valid afterwards, producer 0 wins first.
- With FIFO_ARB_STATS_EN: 7 beats from producer 1, stat_sel=1 -> stat_count=7 one cycle later; stat_sel=0 -> 0.
